// File: rtl/apb_master_ctrl.sv
// APB requester: takes one read/write command at a time, runs SETUP/ACCESS
// with wait-state counting and optional timeout, and returns a held response.
module apb_master_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = $clog2(TIMEOUT + 2)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_write,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic [CNT_W-1:0]  rsp_wait,
   output logic              psel,
   output logic              penable,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam bit               TO_EN   = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Gated by resetn so the port reads 0 while reset is held.
   assign cmd_ready = resetn && (state == IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_wait    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  paddr  <= cmd_addr;
                  pwrite <= cmd_write;
                  pwdata <= cmd_wdata;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_slverr  <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_wait    <= cnt;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (TO_EN && cnt == TO_LAST) begin
                  // This low cycle is the TIMEOUT-th one: the count reaches TIMEOUT now.
                  rsp_rdata   <= '0;
                  rsp_slverr  <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_wait    <= TO_VAL;
                  cnt         <= TO_VAL;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cnt       <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: table of transfers plus a mid-ACCESS reset sequence.
module tb_apb_master_ctrl;

   localparam int TO = 16;
   localparam int CW = $clog2(TO + 2);

   logic          clk, resetn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [31:0]   cmd_addr, cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
   logic [31:0]   rsp_rdata;
   logic [CW-1:0] rsp_wait;
   logic          psel, penable, pwrite, pready, pslverr;
   logic [31:0]   paddr, pwdata, prdata;

   apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .rsp_wait(rsp_wait),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      int          nwait;    // low ACCESS cycles before pready (>= TO means never)
      logic [31:0] prdata;
      logic        slverr;
      int          hold;     // cycles rsp_ready stays low after rsp_valid
      logic [31:0] e_rdata;
      logic        e_slverr;
      logic        e_to;
      int          e_wait;
      int          e_acc;    // expected ACCESS cycles
   } vec_t;

   vec_t vecs[8];
   int   n_cmp = 0;
   int   n_err = 0;
   int   viol  = 0;
   logic prev_psel = 1'b0;

   // Bus rules: penable only with psel, and never in psel's first cycle.
   always @(negedge clk) begin
      if (penable && !psel) viol++;
      if (penable && !prev_psel) viol++;
      prev_psel = psel;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic do_xfer(input vec_t v, input int idx);
      int   acc;
      int   i;
      logic bus_ok;
      logic stable;
      logic [31:0] s_rdata;
      logic [CW-1:0] s_wait;
      logic [1:0] s_flags;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = v.addr; cmd_write = v.write; cmd_wdata = v.wdata;
      chk($sformatf("v%0d.cmd_ready", idx), cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_write = ~v.write;
      @(negedge clk);
      chk($sformatf("v%0d.setup", idx),
          {psel, penable, paddr == v.addr, pwrite == v.write, pwdata == v.wdata}, 5'b10111);
      @(posedge clk); #1;
      acc = 0; i = 0; bus_ok = 1'b1;
      while (psel && acc < 40) begin
         @(negedge clk);
         if (!(psel && penable && paddr == v.addr && pwrite == v.write && pwdata == v.wdata))
            bus_ok = 1'b0;
         pready  = (i == v.nwait);
         pslverr = pready ? v.slverr : 1'b1;
         prdata  = pready ? v.prdata : ~v.prdata;
         i++;
         @(posedge clk); #1;
         acc++;
      end
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      chk($sformatf("v%0d.access_cycles", idx), acc, v.e_acc);
      chk($sformatf("v%0d.bus_stable", idx), bus_ok, 1);
      @(negedge clk);
      chk($sformatf("v%0d.rsp_valid", idx), {rsp_valid, penable}, 2'b10);
      chk($sformatf("v%0d.rdata", idx), rsp_rdata, v.e_rdata);
      chk($sformatf("v%0d.slverr", idx), rsp_slverr, v.e_slverr);
      chk($sformatf("v%0d.timeout", idx), rsp_timeout, v.e_to);
      chk($sformatf("v%0d.wait", idx), rsp_wait, v.e_wait);
      s_rdata = rsp_rdata; s_wait = rsp_wait; s_flags = {rsp_slverr, rsp_timeout};
      if (v.hold > 0) begin
         cmd_valid = 1'b1; cmd_addr = 32'hFFFF_0000; cmd_write = 1'b1;
         stable = 1'b1;
         for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); @(negedge clk);
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || psel !== 1'b0 ||
                rsp_rdata !== s_rdata || rsp_wait !== s_wait ||
                {rsp_slverr, rsp_timeout} !== s_flags)
               stable = 1'b0;
         end
         chk($sformatf("v%0d.backpressure", idx), stable, 1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      chk($sformatf("v%0d.handshake", idx), {rsp_valid, cmd_ready, psel}, 3'b010);
   endtask

   initial begin
      vecs[0] = '{32'h10, 1'b1, 32'hDEAD_BEEF, 0,  32'h5555_5555, 1'b0, 0, 32'h0,         1'b0, 1'b0, 0,  1};
      vecs[1] = '{32'h04, 1'b0, 32'h0,         3,  32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 1'b0, 3,  4};
      vecs[2] = '{32'h08, 1'b0, 32'h0,         1,  32'hAAAA_5555, 1'b1, 0, 32'hAAAA_5555, 1'b1, 1'b0, 1,  2};
      vecs[3] = '{32'h20, 1'b0, 32'h0,         99, 32'h1111_2222, 1'b0, 0, 32'h0,         1'b1, 1'b1, 16, 16};
      vecs[4] = '{32'h24, 1'b0, 32'h0,         15, 32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 15, 16};
      vecs[5] = '{32'h30, 1'b1, 32'h0000_0005, 2,  32'h0000_0077, 1'b1, 0, 32'h0,         1'b1, 1'b0, 2,  3};
      vecs[6] = '{32'h40, 1'b0, 32'h0,         0,  32'h0BAD_C0DE, 1'b0, 5, 32'h0BAD_C0DE, 1'b0, 1'b0, 0,  1};
      vecs[7] = '{32'h44, 1'b1, 32'h0000_0012, 20, 32'h9999_9999, 1'b0, 0, 32'h0,         1'b1, 1'b1, 16, 16};

      resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_wdata = 32'h0;
      rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      #12;
      chk("reset.ctrl", {cmd_ready, rsp_valid, psel, penable, pwrite, rsp_slverr, rsp_timeout}, 7'b0);
      chk("reset.data", {paddr | pwdata | rsp_rdata, rsp_wait}, 0);
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
      chk("post_reset.cmd_ready", cmd_ready, 1);

      for (int k = 0; k < 8; k++) do_xfer(vecs[k], k);

      // Reset during the second wait state of a read.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 32'h50; cmd_write = 1'b0;
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mid.in_access", {psel, penable}, 2'b11);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid.async_drop", {psel, penable, rsp_valid, cmd_ready}, 4'b0);
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
      chk("rst_mid.after_release", {cmd_ready, psel, rsp_valid}, 3'b100);
      do_xfer('{32'h60, 1'b0, 32'h0, 2, 32'h600D_DA7A, 1'b0, 0, 32'h600D_DA7A, 1'b0, 1'b0, 2, 3}, 8);

      chk("protocol_violations", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
Synthesizable APB requester that drives the APB bus consumed by the APB slave side of the UVC.
- Accepts single read/write commands on a valid/ready command port.
- Runs the APB SETUP and ACCESS phases, waiting on pready.
- Returns read data, pslverr, a wait-state count and a timeout flag on a valid/ready response port.
- Sits between a test sequencer or CPU-side adapter and the APB slave.

Parameters:
ADDR_W, 32, width of paddr and cmd_addr
DATA_W, 32, width of pwdata, prdata, cmd_wdata and rsp_rdata
TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables the timeout
CNT_W, $clog2(TIMEOUT+2), width of the wait-state counter (derived; do not override)

Ports:
clk  in  1  bus clock; all logic on the rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_addr  in  ADDR_W  transfer address
cmd_write  in  1  1 = write, 0 = read
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_slverr  out  1  pslverr captured, or forced to 1 on timeout
rsp_timeout  out  1  transfer aborted by timeout
rsp_wait  out  CNT_W  ACCESS cycles with pready low before completion
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
Reset (asynchronous, resetn low):
- All outputs go to 0. State goes to IDLE. Wait counter clears.
- Reset mid-transfer drops psel/penable immediately. The in-flight command and any pending response are discarded.

State machine: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready.
- IDLE
  - cmd_ready = 1, combinational from state only; no combinational path from cmd_valid.
  - On cmd_valid & cmd_ready: register addr/write/wdata onto paddr/pwrite/pwdata and go to SETUP.
  - Without a command, psel=penable=0 and paddr/pwrite/pwdata hold their last values.
- SETUP (exactly 1 cycle)
  - psel=1, penable=0.
  - Go to ACCESS.
- ACCESS
  - psel=1, penable=1.
  - paddr/pwrite/pwdata are stable throughout.
  - Each cycle pready is sampled low, the wait counter increments, saturating at 2^CNT_W-1.
- Completion (pready=1 sampled)
  - rsp_rdata = pwrite ? 0 : prdata.
  - rsp_slverr = pslverr, rsp_timeout = 0, rsp_wait = counter.
  - psel=penable=0 next cycle. Go to RESP.
- Timeout (TIMEOUT>0, counter == TIMEOUT with pready low)
  - rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, rsp_wait=TIMEOUT.
  - psel=penable=0 next cycle. Go to RESP.
  - pready arriving in that same cycle wins: normal completion.
- RESP
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle, counter clears, go to IDLE.
  - cmd_ready=0 in RESP, so no new command is accepted until the response is consumed.

Timing and protocol rules:
- Zero-wait transfer latency: command accept edge → SETUP 1 cycle → ACCESS 1 cycle → rsp_valid high on the following cycle. That is 3 cycles from accept to rsp_valid, minimum 4 cycles per transfer including the return to IDLE.
- pslverr is honoured only in the pready cycle and ignored otherwise.
- prdata is sampled only on a read completion.
- psel never goes high without a registered command.
- penable is never high unless psel is high.
- penable never rises in the same cycle as psel.

Test Plan:
1. Zero-wait write: cmd addr=0x0000_0010, wdata=0xDEAD_BEEF, write=1; slave pready=1 in first ACCESS cycle → psel 2 cycles, penable 1 cycle, pwdata=0xDEAD_BEEF stable; rsp_wait=0, rsp_slverr=0, rsp_rdata=0.
2. Read with 3 wait states: addr=0x0000_0004; slave holds pready low 3 ACCESS cycles then returns prdata=0x1234_5678 → rsp_rdata=0x1234_5678, rsp_wait=3, paddr stable across all 5 bus cycles.
3. Slave error: read, pready=1 with pslverr=1 on second ACCESS cycle → rsp_slverr=1, rsp_timeout=0, rsp_wait=1.
4. Timeout: TIMEOUT=16, slave never asserts pready → after 16 low ACCESS cycles psel drops; rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, rsp_wait=16. Repeat with pready rising exactly at cycle 16 → normal completion.
5. Response backpressure: rsp_ready held low 5 cycles after rsp_valid, cmd_valid held high → cmd_ready stays 0, rsp_* unchanged; second command accepted only after the rsp_ready handshake.
6. Reset mid-ACCESS: drive resetn low during wait state 2 → psel/penable/rsp_valid fall without waiting for clk; after release, cmd_ready=1 and a fresh read completes normally.
